// File: rtl/serdes_pkg.sv
// Shared receive-path definitions: K28.5 comma codes, word-aligner state
// encoding and a helper that extracts a 10-bit symbol from the 20-bit window.
package serdes_pkg;

    localparam logic [9:0] COMMA_P = 10'b0011111010;  // K28.5, RD-
    localparam logic [9:0] COMMA_N = 10'b1100000101;  // K28.5, RD+

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } wa_state_t;

    // Offset k selects window[19-k -: 10]; offsets above 10 return 0.
    function automatic logic [9:0] slice_at(input logic [19:0] win, input logic [3:0] off);
        logic [19:0] sh;
        sh = win >> (5'd10 - {1'b0, off});
        return sh[9:0];
    endfunction

endpackage

// File: rtl/comma_detect_10x.sv
// Combinational K28.5 search across the ten bit offsets of a 20-bit window.
// Reports the lowest matching offset and whether a given offset matches.
module comma_detect_10x #(
    parameter logic [9:0] COMMA_P = 10'b0011111010,
    parameter logic [9:0] COMMA_N = 10'b1100000101
) (
    input  logic [19:0] window,
    input  logic [3:0]  sel_offset,
    output logic        any_hit,
    output logic [3:0]  hit_offset,
    output logic        sel_hit
);

    logic [9:0]  hit_vec;
    logic [15:0] hit_pad;

    for (genvar k = 0; k < 10; k++) begin : g_off
        assign hit_vec[k] = (window[19-k -: 10] == COMMA_P) ||
                            (window[19-k -: 10] == COMMA_N);
    end

    assign any_hit = |hit_vec;
    // Padding keeps out-of-range selects (10..15) reading as no-hit.
    assign hit_pad = {6'b0, hit_vec};
    assign sel_hit = hit_pad[sel_offset];

    always_comb begin
        hit_offset = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (hit_vec[k]) hit_offset = 4'(k);
        end
    end

endmodule

// File: rtl/rx_word_aligner.sv
// 10-bit receive word aligner: hunts for K28.5 at any bit offset, verifies and
// locks, then emits symbol-aligned words. WA_ERR_CNT_EN adds the err_cnt port.
module rx_word_aligner #(
    parameter logic [9:0] COMMA_P    = serdes_pkg::COMMA_P,
    parameter logic [9:0] COMMA_N    = serdes_pkg::COMMA_N,
    parameter int         VERIFY_CNT = 3,
    parameter int         LOSS_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] par_in,
    input  logic       par_valid,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       is_comma,
    output logic       aligned,
    output logic [3:0] align_offset
`ifdef WA_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    import serdes_pkg::*;

    localparam logic [3:0] VCNT = 4'(VERIFY_CNT);
    localparam logic [3:0] LCNT = 4'(LOSS_CNT);

    wa_state_t   state, state_nxt;
    logic [3:0]  offset, offset_nxt;
    logic [3:0]  vcnt, vcnt_nxt;
    logic [3:0]  mcnt, mcnt_nxt;
    logic        err_inc;

    logic [9:0]  prev_word;
    logic        primed;
    logic [19:0] window;
    logic [9:0]  slice_nxt;

    logic        any_hit, sel_hit;
    logic [3:0]  hit_offset;

    assign window = {prev_word, par_in};

    comma_detect_10x #(
        .COMMA_P (COMMA_P),
        .COMMA_N (COMMA_N)
    ) u_det (
        .window     (window),
        .sel_offset (offset),
        .any_hit    (any_hit),
        .hit_offset (hit_offset),
        .sel_hit    (sel_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            offset <= 4'd0;
            vcnt   <= 4'd0;
            mcnt   <= 4'd0;
        end else begin
            state  <= state_nxt;
            offset <= offset_nxt;
            vcnt   <= vcnt_nxt;
            mcnt   <= mcnt_nxt;
        end
    end

    // Cycles without a comma (or before priming) leave everything untouched.
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        vcnt_nxt   = vcnt;
        mcnt_nxt   = mcnt;
        err_inc    = 1'b0;
        if (par_valid && primed && any_hit) begin
            case (state)
                HUNT: begin
                    offset_nxt = hit_offset;
                    vcnt_nxt   = 4'd1;
                    mcnt_nxt   = 4'd0;
                    state_nxt  = (VCNT == 4'd1) ? LOCKED : VERIFY;
                end
                VERIFY: begin
                    if (sel_hit) begin
                        vcnt_nxt = vcnt + 4'd1;
                        if (vcnt + 4'd1 >= VCNT) begin
                            state_nxt = LOCKED;
                            mcnt_nxt  = 4'd0;
                        end
                    end else begin
                        offset_nxt = hit_offset;
                        vcnt_nxt   = 4'd1;
                        err_inc    = 1'b1;
                    end
                end
                LOCKED: begin
                    if (sel_hit) begin
                        mcnt_nxt = 4'd0;
                    end else begin
                        mcnt_nxt = mcnt + 4'd1;
                        err_inc  = 1'b1;
                        if (mcnt + 4'd1 >= LCNT) begin
                            state_nxt = HUNT;
                            mcnt_nxt  = 4'd0;
                            vcnt_nxt  = 4'd0;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // The word that triggers a transition is already cut at the new offset.
    assign slice_nxt = slice_at(window, offset_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word  <= 10'd0;
            primed     <= 1'b0;
            word_out   <= 10'd0;
            word_valid <= 1'b0;
            is_comma   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (par_valid) begin
                prev_word <= par_in;
                primed    <= 1'b1;
                if (primed) begin
                    word_out   <= slice_nxt;
                    is_comma   <= (slice_nxt == COMMA_P) || (slice_nxt == COMMA_N);
                    word_valid <= (state_nxt != HUNT);
                end
            end
        end
    end

    assign aligned      = (state == LOCKED);
    assign align_offset = offset;

`ifdef WA_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cnt <= 8'd0;
        else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`else
    logic err_inc_unused;
    assign err_inc_unused = err_inc;
`endif

endmodule
